// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: active-low hex font,
// special glyphs and the digit-enable helper.
package seg7_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_O     = 8'hC0;
    localparam logic [7:0] SEG_F     = 8'h8E;
    localparam int         DP_BIT    = 7;

    // Element [n] is the glyph for nibble n; dp (bit 7) is off in every entry.
    localparam logic [15:0][7:0] HEX_FONT = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    function automatic logic [3:0] digit_enable(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-low {g,f,e,d,c,b,a} decoder.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg_n
);

    assign seg_n = HEX_FONT[nib][6:0];

endmodule

// File: rtl/seg7_scan_driver.sv
// Latches a result word plus flags and scans one 16-bit half of it as hex
// onto a 4-digit common-anode display, with blanking, sign dp and overflow text.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIV_WIDTH = 17
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] data_in,
    input  logic        neg_in,
    input  logic        ovf_in,
    input  logic        page,
    input  logic        blank_lz,
    output logic [3:0]  an,
    output logic [7:0]  seg,
    output logic        frame_done
);

    logic [31:0]          data_q, data_d;
    logic                 neg_q, neg_d;
    logic                 ovf_q, ovf_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [1:0]           idx_q, idx_d;
    logic [3:0]           an_q, an_d;
    logic [7:0]           seg_q, seg_d;
    logic                 frame_done_q, frame_done_d;

    logic        tick;
    logic [15:0] half;
    logic [3:0]  nibs [4];
    logic [3:0]  upper_zero;
    logic [6:0]  font_seg;

    assign tick = &div_q;
    assign half = page ? data_q[31:16] : data_q[15:0];

    // upper_zero[i]: digit i and every more-significant digit of half are zero.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            assign nibs[gi]       = half[4*gi +: 4];
            assign upper_zero[gi] = (half[15:4*gi] == '0);
        end
    endgenerate

    hex_to_seg7 u_hex_to_seg7 (
        .nib   (nibs[idx_q]),
        .seg_n (font_seg)
    );

    always_comb begin
        div_d        = div_q + 1'b1;
        idx_d        = tick ? idx_q + 2'd1 : idx_q;
        frame_done_d = tick && (idx_q == 2'd3);

        data_d = data_q;
        neg_d  = neg_q;
        ovf_d  = ovf_q;
        if (load) begin
            data_d = data_in;
            neg_d  = neg_in;
            ovf_d  = ovf_in;
        end

        an_d  = digit_enable(idx_q);
        seg_d = {1'b1, font_seg};
        if (ovf_q) begin
            unique case (idx_q)
                2'd3:    seg_d = SEG_O;
                2'd2:    seg_d = SEG_F;
                default: seg_d = SEG_DASH;
            endcase
        end else begin
            if (blank_lz && (idx_q != 2'd0) && upper_zero[idx_q]) begin
                seg_d = SEG_BLANK;
            end
            // The sign dot survives blanking so "-" is visible on small values.
            if (neg_q && (idx_q == 2'd3)) begin
                seg_d[DP_BIT] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q       <= '0;
            neg_q        <= 1'b0;
            ovf_q        <= 1'b0;
            div_q        <= '0;
            idx_q        <= 2'd0;
            an_q         <= 4'b1111;
            seg_q        <= SEG_BLANK;
            frame_done_q <= 1'b0;
        end else begin
            data_q       <= data_d;
            neg_q        <= neg_d;
            ovf_q        <= ovf_d;
            div_q        <= div_d;
            idx_q        <= idx_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver with DIV_WIDTH=2: directed plan
// steps then random loads/options, every edge compared to a reference model.
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [31:0] data_in = '0;
    logic        neg_in = 1'b0;
    logic        ovf_in = 1'b0;
    logic        page = 1'b0;
    logic        blank_lz = 1'b0;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic        frame_done;

    seg7_scan_driver #(.DIV_WIDTH(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .data_in    (data_in),
        .neg_in     (neg_in),
        .ovf_in     (ovf_in),
        .page       (page),
        .blank_lz   (blank_lz),
        .an         (an),
        .seg        (seg),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int fd_count = 0;

    // Reference model: edges since reset release plus the latched word/flags.
    int          m_k = 0;
    logic [31:0] m_data = '0;
    logic        m_neg = 1'b0;
    logic        m_ovf = 1'b0;
    logic [31:0] rv;

    logic [7:0] font [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    function automatic logic [7:0] model_seg(input logic [31:0] dat, input logic neg,
                                             input logic ovf, input logic pg,
                                             input logic blk, input int d);
        logic [15:0] h;
        logic [7:0]  s;
        if (ovf) begin
            if (d == 3) return 8'hC0;
            if (d == 2) return 8'h8E;
            return 8'hBF;
        end
        h = pg ? dat[31:16] : dat[15:0];
        s = font[(h >> (4 * d)) & 16'hF];
        if (blk && d > 0 && (h >> (4 * d)) == 16'h0) s = 8'hFF;
        if (neg && d == 3) s[7] = 1'b0;
        return s;
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) passes++;
        else $error("FAIL %s @k=%0d: got %h expected %h", tag, m_k, act, exp);
    endtask

    // One clock edge: predict from pre-edge state, sample #1 later, advance model.
    task automatic cyc();
        logic [3:0] e_an;
        logic [7:0] e_seg;
        logic       e_fd;
        int         d;
        if (!rst_n) begin
            e_an  = 4'hF;
            e_seg = 8'hFF;
            e_fd  = 1'b0;
        end else begin
            d     = (m_k / 4) % 4;
            e_an  = 4'hF ^ (4'h1 << d);
            e_seg = model_seg(m_data, m_neg, m_ovf, page, blank_lz, d);
            e_fd  = ((m_k % 16) == 15);
        end
        @(posedge clk);
        #1;
        check("an", {28'h0, an}, {28'h0, e_an});
        check("seg", {24'h0, seg}, {24'h0, e_seg});
        check("frame_done", {31'h0, frame_done}, {31'h0, e_fd});
        if (frame_done === 1'b1) fd_count++;
        if (!rst_n) begin
            m_k = 0; m_data = '0; m_neg = 1'b0; m_ovf = 1'b0;
        end else begin
            if (load) begin
                m_data = data_in; m_neg = neg_in; m_ovf = ovf_in;
            end
            m_k++;
        end
    endtask

    task automatic do_load(input logic [31:0] d, input logic n, input logic o);
        data_in = d; neg_in = n; ovf_in = o; load = 1'b1;
        cyc();
        load = 1'b0;
    endtask

    initial begin
        repeat (3) cyc();
        rst_n = 1'b1;
        cyc();
        check("first_an", {28'h0, an}, 32'hE);
        check("first_seg", {24'h0, seg}, 32'hC0);

        do_load(32'h1234ABCD, 1'b0, 1'b0);
        repeat (20) cyc();
        page = 1'b1;
        repeat (16) cyc();
        page = 1'b0;

        blank_lz = 1'b1;
        do_load(32'h00000007, 1'b0, 1'b0);
        repeat (16) cyc();
        do_load(32'h00000000, 1'b0, 1'b0);
        repeat (16) cyc();
        do_load(32'h00000100, 1'b0, 1'b0);
        repeat (16) cyc();

        blank_lz = 1'b0;
        do_load(32'h0000F005, 1'b1, 1'b0);
        repeat (16) cyc();
        blank_lz = 1'b1;
        repeat (16) cyc();
        do_load(32'h0000F005, 1'b1, 1'b1);
        for (int p = 0; p < 2; p++) begin
            for (int b = 0; b < 2; b++) begin
                page = p[0]; blank_lz = b[0];
                repeat (16) cyc();
            end
        end
        page = 1'b0; blank_lz = 1'b0;
        do_load(32'h00C0FFEE, 1'b0, 1'b0);

        fd_count = 0;
        repeat (64) cyc();
        check("fd_per_64", fd_count, 4);

        while (((m_k / 4) % 4) != 2) cyc();
        rst_n = 1'b0;
        cyc();
        check("midreset_an", {28'h0, an}, 32'hF);
        rst_n = 1'b1;
        fd_count = 0;
        repeat (32) cyc();
        check("fd_after_reset", fd_count, 2);

        while ((m_k % 4) != 3) cyc();
        do_load(32'h0000000A, 1'b0, 1'b0);
        repeat (8) cyc();

        repeat (400) begin
            if ($urandom_range(0, 7) == 0) begin
                rv = $urandom >> $urandom_range(0, 31);
                do_load(rv, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
            end else begin
                if ($urandom_range(0, 15) == 0) page = ~page;
                if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
                cyc();
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
